// File: rtl/ram_pkg.sv
// Shared memory-subsystem types: clear/ready state encoding and default word width.
package ram_pkg;

   typedef enum logic {
      CLEAR,
      READY
   } ram_state_t;

   localparam int unsigned RAM_WORD_W = 16;

endpackage

// File: rtl/ram_sync_core.sv
// Storage array with one write port and one registered read port; contents have no reset.
module ram_sync_core
   import ram_pkg::*;
#(
   parameter int unsigned WIDTH      = RAM_WORD_W,
   parameter int unsigned DEPTH_LOG2 = 14
) (
   input  logic                  clk,
   input  logic                  we,
   input  logic [DEPTH_LOG2-1:0] waddr,
   input  logic [WIDTH-1:0]      wdata,
   input  logic                  rd,
   input  logic [DEPTH_LOG2-1:0] raddr,
   output logic [WIDTH-1:0]      q
);

   localparam int unsigned DEPTH = 2 ** DEPTH_LOG2;

   logic [WIDTH-1:0] mem [DEPTH];

   // Non-blocking update gives read-first data on a same-address collision.
   always_ff @(posedge clk) begin
      if (we)
         mem[waddr] <= wdata;
      if (rd)
         q <= mem[raddr];
   end

endmodule

// File: rtl/ram_sync_clr.sv
// Single-port synchronous RAM with post-reset clear sweep, rvalid strobe and busy flag.
// Define RAM_SYNC_CLR_BYPASS_EN for write-first forwarding on same-cycle read+write.
module ram_sync_clr
   import ram_pkg::*;
#(
   parameter int unsigned     WIDTH      = RAM_WORD_W,
   parameter int unsigned     DEPTH_LOG2 = 14,
   parameter logic [WIDTH-1:0] CLEAR_VAL = '0
) (
   input  logic                  clk,
   input  logic                  re,
   input  logic                  e,
   input  logic                  w,
   input  logic                  r,
   input  logic [DEPTH_LOG2-1:0] addr,
   input  logic [WIDTH-1:0]      DIn,
   output logic [WIDTH-1:0]      DOut,
   output logic                  rvalid,
   output logic                  busy
);

   localparam logic [DEPTH_LOG2-1:0] LAST_ADDR = '1;

   ram_state_t            state, state_nx;
   logic [DEPTH_LOG2-1:0] clr_addr;
   logic                  busy_q, rvalid_q, dout_zero;
   logic                  mem_we, req_rd;
   logic [DEPTH_LOG2-1:0] mem_waddr;
   logic [WIDTH-1:0]      mem_wdata, core_q;

   always_comb begin
      state_nx  = state;
      mem_we    = 1'b0;
      mem_waddr = addr;
      mem_wdata = DIn;
      req_rd    = 1'b0;
      if (!re) begin
         case (state)
            CLEAR: begin
               mem_we    = 1'b1;
               mem_waddr = clr_addr;
               mem_wdata = CLEAR_VAL;
               if (clr_addr == LAST_ADDR)
                  state_nx = READY;
            end
            READY: begin
               mem_we = e & w;
               req_rd = e & r;
            end
            default: state_nx = CLEAR;
         endcase
      end
   end

   // DOut is forced to zero after reset until the first accepted read reloads it.
   always_ff @(posedge clk) begin
      if (re) begin
         state     <= CLEAR;
         clr_addr  <= '0;
         busy_q    <= 1'b1;
         rvalid_q  <= 1'b0;
         dout_zero <= 1'b1;
      end else begin
         state    <= state_nx;
         busy_q   <= (state_nx == CLEAR);
         rvalid_q <= req_rd;
         if (state == CLEAR)
            clr_addr <= clr_addr + 1'b1;
         if (req_rd)
            dout_zero <= 1'b0;
      end
   end

   ram_sync_core #(
      .WIDTH      (WIDTH),
      .DEPTH_LOG2 (DEPTH_LOG2)
   ) u_core (
      .clk   (clk),
      .we    (mem_we),
      .waddr (mem_waddr),
      .wdata (mem_wdata),
      .rd    (req_rd),
      .raddr (addr),
      .q     (core_q)
   );

`ifdef RAM_SYNC_CLR_BYPASS_EN
   logic             fwd;
   logic [WIDTH-1:0] fwd_data;

   always_ff @(posedge clk) begin
      if (re) begin
         fwd <= 1'b0;
      end else if (req_rd) begin
         fwd      <= mem_we;
         fwd_data <= DIn;
      end
   end

   assign DOut = dout_zero ? '0 : (fwd ? fwd_data : core_q);
`else
   assign DOut = dout_zero ? '0 : core_q;
`endif

   assign rvalid = rvalid_q;
   assign busy   = busy_q;

endmodule

// File: tb/tb_ram_sync_clr.sv
// Directed self-checking bench for ram_sync_clr (16-bit words, 16 entries, clear value 16'h00A5).
module tb_ram_sync_clr;

   localparam int unsigned WIDTH      = 16;
   localparam int unsigned DEPTH_LOG2 = 4;
   localparam logic [15:0] CLR        = 16'h00A5;

   logic                  clk = 1'b0;
   logic                  re, e, w, r;
   logic [DEPTH_LOG2-1:0] addr;
   logic [WIDTH-1:0]      DIn, DOut;
   logic                  rvalid, busy;

   int unsigned checks   = 0;
   int unsigned failures = 0;

   ram_sync_clr #(
      .WIDTH      (WIDTH),
      .DEPTH_LOG2 (DEPTH_LOG2),
      .CLEAR_VAL  (CLR)
   ) dut (
      .clk    (clk),
      .re     (re),
      .e      (e),
      .w      (w),
      .r      (r),
      .addr   (addr),
      .DIn    (DIn),
      .DOut   (DOut),
      .rvalid (rvalid),
      .busy   (busy)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic req(input logic en, input logic wr, input logic rd,
                      input logic [DEPTH_LOG2-1:0] a, input logic [WIDTH-1:0] d);
      e = en; w = wr; r = rd; addr = a; DIn = d;
   endtask

   int unsigned busy_edges;
   logic        any_rv;
   logic [WIDTH-1:0] same_cycle_exp;

   initial begin
`ifdef RAM_SYNC_CLR_BYPASS_EN
      same_cycle_exp = 16'h0002;
`else
      same_cycle_exp = 16'h0001;
`endif
      re = 1'b1;
      req(1'b0, 1'b0, 1'b0, '0, '0);
      tick();
      check("rst_busy", 32'(busy), 32'd1);
      check("rst_rvalid", 32'(rvalid), 32'd0);
      check("rst_dout", 32'(DOut), 32'd0);

      // sweep with a write+read to address 3 pending the whole time
      re = 1'b0;
      req(1'b1, 1'b1, 1'b1, 4'd3, 16'hFFFF);
      busy_edges = 0;
      any_rv     = 1'b0;
      for (int i = 0; i < 40; i++) begin
         tick();
         busy_edges++;
         any_rv |= rvalid;
         if (!busy) break;
      end
      req(1'b0, 1'b0, 1'b0, '0, '0);
      check("sweep_edges", busy_edges, 32'd16);
      check("busy_no_rvalid", 32'(any_rv), 32'd0);

      for (int i = 0; i < 16; i++) begin
         req(1'b1, 1'b0, 1'b1, DEPTH_LOG2'(i), '0);
         tick();
         check($sformatf("clr_data_%0d", i), 32'(DOut), 32'(CLR));
         check($sformatf("clr_rvalid_%0d", i), 32'(rvalid), 32'd1);
      end
      req(1'b0, 1'b0, 1'b0, '0, '0);
      tick();
      check("rvalid_drop", 32'(rvalid), 32'd0);
      check("dout_hold_clr", 32'(DOut), 32'(CLR));

      // write then read back next cycle
      req(1'b1, 1'b1, 1'b0, 4'd5, 16'h1234);
      tick();
      check("wr_no_rvalid", 32'(rvalid), 32'd0);
      req(1'b1, 1'b0, 1'b1, 4'd5, '0);
      tick();
      check("wr_rd_data", 32'(DOut), 32'h1234);
      check("wr_rd_rvalid", 32'(rvalid), 32'd1);
      req(1'b0, 1'b0, 1'b0, '0, '0);
      tick();
      tick();
      check("idle_hold", 32'(DOut), 32'h1234);
      check("idle_rvalid", 32'(rvalid), 32'd0);

      // same-cycle read and write
      req(1'b1, 1'b1, 1'b0, 4'd3, 16'h0001);
      tick();
      req(1'b1, 1'b1, 1'b1, 4'd3, 16'h0002);
      tick();
      check("rw_same_data", 32'(DOut), 32'(same_cycle_exp));
      check("rw_same_rvalid", 32'(rvalid), 32'd1);
      req(1'b1, 1'b0, 1'b1, 4'd3, '0);
      tick();
      check("rw_after", 32'(DOut), 32'h0002);

      // enable gating
      req(1'b0, 1'b1, 1'b1, 4'd5, 16'hBEEF);
      tick();
      check("gate_rvalid", 32'(rvalid), 32'd0);
      check("gate_hold", 32'(DOut), 32'h0002);
      req(1'b1, 1'b0, 1'b1, 4'd5, '0);
      tick();
      check("gate_mem", 32'(DOut), 32'h1234);
      req(1'b0, 1'b0, 1'b0, '0, '0);

      // reset again, then re-assert it seven edges into the sweep
      re = 1'b1;
      tick();
      re = 1'b0;
      for (int i = 0; i < 7; i++) tick();
      check("mid_busy", 32'(busy), 32'd1);
      re = 1'b1;
      tick();
      check("mid_rst_busy", 32'(busy), 32'd1);
      check("mid_rst_dout", 32'(DOut), 32'd0);
      check("mid_rst_rvalid", 32'(rvalid), 32'd0);
      re = 1'b0;
      busy_edges = 0;
      for (int i = 0; i < 40; i++) begin
         tick();
         busy_edges++;
         if (!busy) break;
      end
      check("mid_sweep_edges", busy_edges, 32'd16);
      req(1'b1, 1'b0, 1'b1, 4'd5, '0);
      tick();
      check("mid_clr_data", 32'(DOut), 32'(CLR));
      req(1'b0, 1'b0, 1'b0, '0, '0);
      tick();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
